// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor with Execute-stage resolver.
// Predicts in Fetch, resolves/redirects and trains in Execute.
module branch_predict_unit #(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 2,
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   pcF,
   output logic              predictF,
   output logic [PC_W-1:0]   predTargetF,
   input  logic              validE,
   input  logic [PC_W-1:0]   pcE,
   input  logic              branchE,
   input  logic [1:0]        jumpE,
   input  logic [2:0]        funct3E,
   input  logic              N,
   input  logic              Z,
   input  logic              C,
   input  logic              V,
   input  logic [PC_W-1:0]   pcTargetE,
   input  logic              predictionE,
   input  logic [PC_W-1:0]   predTargetE,
   output logic              takenE,
   output logic              redirectE,
   output logic [PC_W-1:0]   redirectPcE,
   output logic [STAT_W-1:0] branchCnt,
   output logic [STAT_W-1:0] mispredCnt
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_LO  = IDX_W + 2;
   localparam int TAG_HI  = IDX_W + TAG_W + 1;

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_MAX >> 1;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_jal;
   logic [CNT_W-1:0]   r_cnt    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [PC_W-1:0]    r_target [ENTRIES];

   logic [STAT_W-1:0] r_branchCnt;
   logic [STAT_W-1:0] r_mispredCnt;

   logic [IDX_W-1:0] w_idxF;
   logic [TAG_W-1:0] w_tagF;
   logic             w_hitF;
   logic [IDX_W-1:0] w_idxE;
   logic [TAG_W-1:0] w_tagE;
   logic             w_cond;
   logic             w_jal;
   logic             w_jalr;
   logic             w_brTaken;
   logic             w_tgtMiss;
   logic [PC_W-1:0]  w_pc4;
   logic             w_unused;

   // ---------------- Fetch lookup ----------------
   assign w_idxF = pcF[TAG_LO-1:2];
   assign w_tagF = pcF[TAG_HI:TAG_LO];
   assign w_hitF = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);

   assign predictF    = w_hitF &&
                        (r_jal[w_idxF] || r_cnt[w_idxF][CNT_W-1]);
   assign predTargetF = predictF ? r_target[w_idxF] : '0;

   // ---------------- Execute resolve ----------------
   assign w_idxE = pcE[TAG_LO-1:2];
   assign w_tagE = pcE[TAG_HI:TAG_LO];

   always_comb begin
      w_cond = 1'b0;
      case (funct3E)
         3'b000:  w_cond = Z;
         3'b001:  w_cond = !Z;
         3'b100:  w_cond = (N != V);
         3'b101:  w_cond = (N == V);
         3'b110:  w_cond = !C;
         3'b111:  w_cond = C;
         default: w_cond = 1'b0;
      endcase
   end

   // jumpE = 11 decodes to neither jal nor jalr
   assign w_jal     = (jumpE == 2'b01);
   assign w_jalr    = (jumpE == 2'b10);
   assign w_brTaken = branchE && w_cond;
   assign takenE    = validE && (w_brTaken || w_jal || w_jalr);

   assign w_pc4     = pcE + PC_W'(4);
   assign w_tgtMiss = !predictionE || (predTargetE != pcTargetE);

   always_comb begin
      redirectE   = 1'b0;
      redirectPcE = w_pc4;
      if (validE) begin
         if (w_jalr) begin
            redirectE   = 1'b1;
            redirectPcE = pcTargetE;
         end else if (takenE && w_tgtMiss) begin
            redirectE   = 1'b1;
            redirectPcE = pcTargetE;
         end else if (!takenE && predictionE) begin
            redirectE   = 1'b1;
            redirectPcE = w_pc4;
         end
      end
   end

   // ---------------- Training: valid + counters ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_cnt[i] <= CNT_INIT;
         end
      end else if (validE) begin
         if (branchE) begin
            if (w_cond) begin
               r_valid[w_idxE] <= 1'b1;
               if (r_cnt[w_idxE] != CNT_MAX) begin
                  r_cnt[w_idxE] <= r_cnt[w_idxE] + CNT_W'(1);
               end
            end else if (r_cnt[w_idxE] != '0) begin
               r_cnt[w_idxE] <= r_cnt[w_idxE] - CNT_W'(1);
            end
         end else if (w_jal) begin
            r_valid[w_idxE] <= 1'b1;
            r_cnt[w_idxE]   <= CNT_MAX;
         end else if (!w_jalr && predictionE) begin
            // false hit on a non-control instruction
            r_valid[w_idxE] <= 1'b0;
         end
      end
   end

   // ---------------- Training: payload (gated by valid) ----------------
   always_ff @(posedge clk) begin
      if (!reset && validE) begin
         if (branchE && w_cond) begin
            r_tag[w_idxE]    <= w_tagE;
            r_target[w_idxE] <= pcTargetE;
            r_jal[w_idxE]    <= 1'b0;
         end else if (!branchE && w_jal) begin
            r_tag[w_idxE]    <= w_tagE;
            r_target[w_idxE] <= pcTargetE;
            r_jal[w_idxE]    <= 1'b1;
         end
      end
   end

   // ---------------- Performance counters ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_branchCnt  <= '0;
         r_mispredCnt <= '0;
      end else if (validE) begin
         if (branchE && (r_branchCnt != STAT_MAX)) begin
            r_branchCnt <= r_branchCnt + STAT_W'(1);
         end
         if (redirectE && (r_mispredCnt != STAT_MAX)) begin
            r_mispredCnt <= r_mispredCnt + STAT_W'(1);
         end
      end
   end

   assign branchCnt  = r_branchCnt;
   assign mispredCnt = r_mispredCnt;

   assign w_unused = ^{pcF[1:0], pcF[PC_W-1:TAG_HI],
                       pcE[1:0], pcE[PC_W-1:TAG_HI]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a table-level model
// checked every cycle plus hand-computed literal expectations.
module tb_branch_predict_unit;

   localparam int ENT  = 64;
   localparam int CMAX = 3;
   localparam int CINI = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcF;
   logic        validE;
   logic [31:0] pcE;
   logic        branchE;
   logic [1:0]  jumpE;
   logic [2:0]  funct3E;
   logic        N, Z, C, V;
   logic [31:0] pcTargetE;
   logic        predictionE;
   logic [31:0] predTargetE;

   logic        predictF;
   logic [31:0] predTargetF;
   logic        takenE;
   logic        redirectE;
   logic [31:0] redirectPcE;
   logic [31:0] branchCnt;
   logic [31:0] mispredCnt;

   logic        s_predictF;
   logic [31:0] s_predTargetF;
   logic        s_takenE;
   logic        s_redirectE;
   logic [31:0] s_redirectPcE;
   logic [2:0]  s_branchCnt;
   logic [2:0]  s_mispredCnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predict_unit u_dut (
      .clk(clk), .reset(reset), .pcF(pcF),
      .predictF(predictF), .predTargetF(predTargetF),
      .validE(validE), .pcE(pcE), .branchE(branchE),
      .jumpE(jumpE), .funct3E(funct3E),
      .N(N), .Z(Z), .C(C), .V(V),
      .pcTargetE(pcTargetE), .predictionE(predictionE),
      .predTargetE(predTargetE), .takenE(takenE),
      .redirectE(redirectE), .redirectPcE(redirectPcE),
      .branchCnt(branchCnt), .mispredCnt(mispredCnt)
   );

   // narrow counters so saturation is reachable
   branch_predict_unit #(.STAT_W(3)) u_sat (
      .clk(clk), .reset(reset), .pcF(pcF),
      .predictF(s_predictF), .predTargetF(s_predTargetF),
      .validE(validE), .pcE(pcE), .branchE(branchE),
      .jumpE(jumpE), .funct3E(funct3E),
      .N(N), .Z(Z), .C(C), .V(V),
      .pcTargetE(pcTargetE), .predictionE(predictionE),
      .predTargetE(predTargetE), .takenE(s_takenE),
      .redirectE(s_redirectE), .redirectPcE(s_redirectPcE),
      .branchCnt(s_branchCnt), .mispredCnt(s_mispredCnt)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // ---------------- model ----------------
   bit          m_init = 1'b0;
   bit          m_valid  [ENT];
   bit          m_jal    [ENT];
   int          m_cnt    [ENT];
   int          m_tag    [ENT];
   logic [31:0] m_target [ENT];
   longint      m_br;
   longint      m_mis;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> 8) % 256);
   endfunction

   function automatic bit m_cond();
      case (funct3E)
         3'd0: return Z;
         3'd1: return !Z;
         3'd4: return N != V;
         3'd5: return N == V;
         3'd6: return !C;
         3'd7: return C;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_taken();
      return validE && ((branchE && m_cond()) ||
                        jumpE == 2'b01 || jumpE == 2'b10);
   endfunction

   function automatic bit m_to_tgt();
      return validE && (jumpE == 2'b10 || (m_taken() &&
             (!predictionE || predTargetE != pcTargetE)));
   endfunction

   function automatic bit m_redir();
      return m_to_tgt() || (validE && !m_taken() && predictionE);
   endfunction

   function automatic logic [31:0] m_rpc();
      return m_to_tgt() ? pcTargetE : pcE + 32'd4;
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      return m_valid[i] && m_tag[i] == tag_of(pc) &&
             (m_jal[i] || m_cnt[i] >= 2);
   endfunction

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_init <= 1'b1;
         m_br   <= 0;
         m_mis  <= 0;
         for (int i = 0; i < ENT; i++) begin
            m_valid[i] <= 1'b0;
            m_cnt[i]   <= CINI;
         end
      end else if (m_init && validE) begin
         m_mis <= m_mis + (m_redir() ? 1 : 0);
         m_br  <= m_br + (branchE ? 1 : 0);
         if (branchE && m_cond()) begin
            m_cnt[idx_of(pcE)]    <= (m_cnt[idx_of(pcE)] < CMAX) ?
                                     m_cnt[idx_of(pcE)] + 1 : CMAX;
            m_valid[idx_of(pcE)]  <= 1'b1;
            m_tag[idx_of(pcE)]    <= tag_of(pcE);
            m_target[idx_of(pcE)] <= pcTargetE;
            m_jal[idx_of(pcE)]    <= 1'b0;
         end else if (branchE) begin
            m_cnt[idx_of(pcE)] <= (m_cnt[idx_of(pcE)] > 0) ?
                                  m_cnt[idx_of(pcE)] - 1 : 0;
         end else if (jumpE == 2'b01) begin
            m_cnt[idx_of(pcE)]    <= CMAX;
            m_valid[idx_of(pcE)]  <= 1'b1;
            m_tag[idx_of(pcE)]    <= tag_of(pcE);
            m_target[idx_of(pcE)] <= pcTargetE;
            m_jal[idx_of(pcE)]    <= 1'b1;
         end else if (jumpE != 2'b10 && predictionE) begin
            m_valid[idx_of(pcE)] <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_init) begin
         chk("m_predictF", 32'(predictF), 32'(m_pred(pcF)));
         chk("m_predTargetF", predTargetF,
             m_pred(pcF) ? m_target[idx_of(pcF)] : 32'd0);
         chk("m_takenE", 32'(takenE), 32'(m_taken()));
         chk("m_redirectE", 32'(redirectE), 32'(m_redir()));
         chk("m_redirectPcE", redirectPcE, m_rpc());
         chk("m_branchCnt", branchCnt, 32'(sat(m_br, 64'hFFFFFFFF)));
         chk("m_mispredCnt", mispredCnt, 32'(sat(m_mis, 64'hFFFFFFFF)));
         chk("m_s_branchCnt", 32'(s_branchCnt), 32'(sat(m_br, 7)));
         chk("m_s_mispredCnt", 32'(s_mispredCnt), 32'(sat(m_mis, 7)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic ex(input bit v, input logic [31:0] pc,
                     input bit br, input logic [1:0] j,
                     input logic [2:0] f3, input logic [3:0] nzcv,
                     input logic [31:0] tgt, input bit pr,
                     input logic [31:0] ptg);
      validE      = v;
      pcE         = pc;
      branchE     = br;
      jumpE       = j;
      funct3E     = f3;
      {N, Z, C, V} = nzcv;
      pcTargetE   = tgt;
      predictionE = pr;
      predTargetE = ptg;
      #1;
   endtask

   task automatic bubble();
      ex(0, 32'h0, 0, 2'b00, 3'd0, 4'h0, 32'h0, 0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] FZ  = 4'b0100;
   localparam logic [3:0] FNV = 4'b1001;

   initial begin
      reset = 1'b1;
      pcF   = 32'h0;
      bubble();
      tick();
      tick();
      reset = 1'b0;

      // reset state and cold taken beq
      pcF = 32'h40;
      bubble();
      chk("rst_predictF", 32'(predictF), 32'd0);
      chk("rst_predTargetF", predTargetF, 32'd0);
      chk("rst_branchCnt", branchCnt, 32'd0);
      chk("rst_mispredCnt", mispredCnt, 32'd0);
      tick();
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 0, 32'h0);
      chk("cold_taken", 32'(takenE), 32'd1);
      chk("cold_redirect", 32'(redirectE), 32'd1);
      chk("cold_redirectPc", redirectPcE, 32'h80);
      tick();
      bubble();
      chk("cold_mispredCnt", mispredCnt, 32'd1);
      chk("cold_branchCnt", branchCnt, 32'd1);

      // second taken beq, predicted correctly
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 1, 32'h80);
      chk("hit_redirect", 32'(redirectE), 32'd0);
      chk("hit_redirectPc", redirectPcE, 32'h44);
      tick();
      bubble();
      chk("train_predictF", 32'(predictF), 32'd1);
      chk("train_predTarget", predTargetF, 32'h80);

      // walk down 11->10->01->00->00
      for (int k = 0; k < 4; k++) begin
         ex(1, 32'h40, 1, 2'b00, 3'd0, 4'h0, 32'h80, 0, 32'h0);
         tick();
         bubble();
         chk("walk_predictF", 32'(predictF), (k == 0) ? 32'd1 : 32'd0);
      end
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 0, 32'h0);
      tick();
      bubble();
      chk("floor_predictF", 32'(predictF), 32'd0);
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 0, 32'h0);
      tick();
      bubble();
      chk("reup_predictF", 32'(predictF), 32'd1);
      chk("walk_mispredCnt", mispredCnt, 32'd3);
      chk("walk_branchCnt", branchCnt, 32'd8);

      // wrong prediction and a correct bge
      ex(1, 32'h40, 1, 2'b00, 3'b001, FZ, 32'h80, 1, 32'h80);
      chk("bne_taken", 32'(takenE), 32'd0);
      chk("bne_redirect", 32'(redirectE), 32'd1);
      chk("bne_redirectPc", redirectPcE, 32'h44);
      tick();
      ex(1, 32'h40, 1, 2'b00, 3'b101, FNV, 32'h80, 1, 32'h80);
      chk("bge_taken", 32'(takenE), 32'd1);
      chk("bge_redirect", 32'(redirectE), 32'd0);
      tick();
      bubble();
      chk("bge_mispredCnt", mispredCnt, 32'd4);
      chk("bge_branchCnt", branchCnt, 32'd10);

      // jal then jalr
      pcF = 32'h100;
      ex(1, 32'h100, 0, 2'b01, 3'd0, 4'h0, 32'h200, 0, 32'h0);
      chk("jal_cold_predictF", 32'(predictF), 32'd0);
      chk("jal_redirect", 32'(redirectE), 32'd1);
      chk("jal_redirectPc", redirectPcE, 32'h200);
      tick();
      bubble();
      chk("jal_predictF", 32'(predictF), 32'd1);
      chk("jal_predTarget", predTargetF, 32'h200);
      ex(1, 32'h100, 0, 2'b01, 3'd0, 4'h0, 32'h200, 1, 32'h200);
      chk("jal_hit_redirect", 32'(redirectE), 32'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         ex(1, 32'h104, 0, 2'b10, 3'd0, 4'h0, 32'h300, 0, 32'h0);
         chk("jalr_redirect", 32'(redirectE), 32'd1);
         chk("jalr_redirectPc", redirectPcE, 32'h300);
         tick();
      end
      pcF = 32'h104;
      bubble();
      chk("jalr_nopredict", 32'(predictF), 32'd0);
      chk("jj_branchCnt", branchCnt, 32'd10);
      chk("jj_mispredCnt", mispredCnt, 32'd10);
      chk("sat_mispredCnt", 32'(s_mispredCnt), 32'd7);
      chk("sat_branchCnt", 32'(s_branchCnt), 32'd7);
      pcF = 32'h40;
      bubble();
      chk("pre_alias_predictF", 32'(predictF), 32'd1);

      // aliasing non-branch clears the entry
      pcF = 32'h140;
      ex(1, 32'h140, 0, 2'b00, 3'd0, 4'h0, 32'h0, 1, 32'h80);
      chk("alias_tagmiss", 32'(predictF), 32'd0);
      chk("alias_redirect", 32'(redirectE), 32'd1);
      chk("alias_redirectPc", redirectPcE, 32'h144);
      tick();
      pcF = 32'h40;
      bubble();
      chk("alias_cleared", 32'(predictF), 32'd0);

      // same-index write/read: fetch sees the old jal entry
      pcF = 32'h100;
      ex(1, 32'h200, 1, 2'b00, 3'd0, FZ, 32'h400, 0, 32'h0);
      chk("rbw_old_predictF", 32'(predictF), 32'd1);
      chk("rbw_old_target", predTargetF, 32'h200);
      tick();
      bubble();
      chk("rbw_evicted", 32'(predictF), 32'd0);
      pcF = 32'h200;
      bubble();
      chk("rbw_new_predictF", 32'(predictF), 32'd1);
      chk("rbw_new_target", predTargetF, 32'h400);

      // validE=0 has no effect
      pcF = 32'h300;
      ex(0, 32'h300, 0, 2'b01, 3'd0, 4'h0, 32'h500, 1, 32'h500);
      chk("bubble_redirect", 32'(redirectE), 32'd0);
      chk("bubble_taken", 32'(takenE), 32'd0);
      tick();
      bubble();
      chk("bubble_predictF", 32'(predictF), 32'd0);
      chk("bubble_mispredCnt", mispredCnt, 32'd12);
      chk("bubble_branchCnt", branchCnt, 32'd11);

      // pc+4 wraps to zero
      ex(1, 32'hFFFFFFFC, 1, 2'b00, 3'd0, 4'h0, 32'h80, 1, 32'h80);
      chk("wrap_redirect", 32'(redirectE), 32'd1);
      chk("wrap_redirectPc", redirectPcE, 32'h0);
      tick();
      bubble();
      chk("wrap_mispredCnt", mispredCnt, 32'd13);
      chk("wrap_sat_mispred", 32'(s_mispredCnt), 32'd7);

      // reset mid-training
      pcF = 32'h40;
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 1, 32'h80);
      tick();
      bubble();
      chk("pre_rst_predictF", 32'(predictF), 32'd1);
      reset = 1'b1;
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 0, 32'h0);
      chk("rst_cycle_redirect", 32'(redirectE), 32'd1);
      tick();
      reset = 1'b0;
      bubble();
      chk("mid_rst_predictF", 32'(predictF), 32'd0);
      chk("mid_rst_predTarget", predTargetF, 32'd0);
      chk("mid_rst_branchCnt", branchCnt, 32'd0);
      chk("mid_rst_mispredCnt", mispredCnt, 32'd0);
      ex(1, 32'h40, 1, 2'b00, 3'd0, 4'h0, 32'h80, 0, 32'h0);
      tick();
      ex(1, 32'h40, 1, 2'b00, 3'd0, FZ, 32'h80, 0, 32'h0);
      tick();
      bubble();
      chk("mid_rst_cnt_init", 32'(predictF), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
